demux_1_2: RTL
==============

# demux_1_2

Registered 1-to-2 demultiplexer with valid/ready handshaking. It steers one input stream to one of two output ports, chosen per transfer by `select`. It is the distribution-side counterpart of the 2:1 datapath mux: a single producer feeds two consumers, such as writeback/forwarding paths or two functional units. Each output port has its own single-entry output register, so one port stalling never blocks transfers to the other. A per-port transfer counter supports debug and verification.

## Interface
- `width`, 5, data bits per transfer
- `cnt_w`, 8, width of each per-port transfer counter
- `clk`  input  1  clock; all state changes on the rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `in_data`  input  width  input payload
- `in_valid`  input  1  producer offers `in_data`
- `select`  input  1  destination, sampled with `in_valid`: 0 → port 1, 1 → port 2
- `in_ready`  output  1  block accepts the offered transfer this cycle (combinational)
- `out1_data`  output  width  port 1 payload (registered)
- `out1_valid`  output  1  port 1 holds a transfer
- `out1_ready`  input  1  port 1 consumer accepts
- `out2_data`  output  width  port 2 payload (registered)
- `out2_valid`  output  1  port 2 holds a transfer
- `out2_ready`  input  1  port 2 consumer accepts
- `cnt1`  output  cnt_w  transfers accepted into port 1, modulo 2^cnt_w
- `cnt2`  output  cnt_w  transfers accepted into port 2, modulo 2^cnt_w

## Operation
- Each port has a 2-state FSM with states EMPTY (`outN_valid`=0) and FULL (`outN_valid`=1).
- Port N is available when it is EMPTY, or when it is FULL and `outN_ready`=1, i.e. it drains this cycle.
- `in_ready` = available(port 1) when `select`=0; available(port 2) when `select`=1. `in_ready` is forced to 0 while `reset_n`=0.
- An input transfer happens when `in_valid` & `in_ready`. At that edge, `in_data` loads into the selected port's data register, its valid goes to 1, and its counter increments.
- Transitions for the selected port:
  - EMPTY → FULL on an accept.
  - FULL → FULL on drain plus accept in the same cycle; the data is replaced and valid stays 1 with no bubble.
  - FULL → EMPTY on drain with no accept.
- The unselected port only ever drains; it is never loaded that cycle.
- `in_ready` depends on `select`, so it may toggle when `select` changes while `in_valid`=1. The producer must hold `select` and `in_data` stable while `in_valid`=1 and `in_ready`=0.
- Output hold rule: while `outN_valid`=1 and `outN_ready`=0, `outN_data` and `outN_valid` stay unchanged.
- `outN_ready` with `outN_valid`=0 is ignored.
- Counters wrap from 2^cnt_w−1 to 0 without a flag.
- Data registers are not cleared on a drain; their content is don't-care while valid=0.

## Timing
- Latency is 1 cycle: data accepted at edge k is visible on `outN_data` with `outN_valid`=1 after edge k.
- Throughput per port is 1 transfer per cycle when the consumer holds `outN_ready`=1 continuously.
- No combinational path from `in_data` to `outN_data`. The only combinational path is `outN_ready`/`select` → `in_ready`.
- Reset (asynchronous on `reset_n` falling, released synchronously by the caller) forces:
  - `out1_valid`=`out2_valid`=0
  - `out1_data`=`out2_data`=0
  - `cnt1`=`cnt2`=0
  - `in_ready`=0
- Reset mid-operation discards held transfers immediately, without waiting for a clock edge.
- First accept is possible on the first rising edge after `reset_n` returns to 1.

## Test plan
- **Reset:** assert `reset_n`=0 mid-cycle with both ports FULL → both valids and both counters read 0 before the next edge; `in_ready`=0.
- **Basic steer:** `in_data`=5'h0A, `select`=0, `in_valid`=1, `out1_ready`=1 for one cycle → next cycle `out1_valid`=1, `out1_data`=5'h0A, `cnt1`=1, `out2_valid`=0.
- **Backpressure isolation:**
  - Port 1 FULL with `out1_ready`=0, then offer `select`=0 → `in_ready`=0 and `out1_data` holds.
  - Switch to `select`=1 → accepted into port 2 the same cycle.
- **Back-to-back replace:** port 2 FULL with 5'h03, `out2_ready`=1, accept 5'h1F to port 2 → `out2_valid` stays 1 and `out2_data`=5'h1F after the edge; `cnt2` increments by 1.
- **Streaming alternation:** 20 transfers with alternating `select`, both readies held at 1 → `in_ready` constantly 1, `cnt1`=`cnt2`=10, each output sequence is in order with no loss or duplication.
- **Counter wrap:** 256 accepts to port 1 with `cnt_w`=8 → `cnt1` returns to 0, `cnt2` unchanged.

Source files
------------

// File: rtl/demux_1_2.sv
// Registered 1-to-2 demultiplexer with valid/ready handshaking.
// Each output port owns a single-entry register so a stalled consumer never blocks the other port.
module demux_1_2 #(
    parameter int width = 5,
    parameter int cnt_w = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    input  logic             select,
    output logic             in_ready,
    output logic [width-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [width-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [cnt_w-1:0] cnt1,
    output logic [cnt_w-1:0] cnt2
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    port_state_t      st1_q, st2_q;
    logic [width-1:0] data1_q, data2_q;
    logic [cnt_w-1:0] cnt1_q, cnt2_q;

    logic avail1_s, avail2_s, accept1_s, accept2_s;

    // Port availability, producer handshake and per-port accept strobes
    always_comb begin
        avail1_s  = (st1_q == EMPTY) || out1_ready;
        avail2_s  = (st2_q == EMPTY) || out2_ready;
        if (select == 1'b1) begin
            in_ready = reset_n & avail2_s;
        end else begin
            in_ready = reset_n & avail1_s;
        end
        accept1_s = in_valid & in_ready & ~select;
        accept2_s = in_valid & in_ready & select;
    end

    // Port 1 FSM: an accept always wins over a drain, giving bubble-free replace
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st1_q   <= EMPTY;
            data1_q <= {width{1'b0}};
            cnt1_q  <= {cnt_w{1'b0}};
        end else begin
            case (st1_q)
                EMPTY: begin
                    if (accept1_s) begin
                        st1_q   <= FULL;
                        data1_q <= in_data;
                        cnt1_q  <= cnt1_q + {{(cnt_w-1){1'b0}}, 1'b1};
                    end
                end
                FULL: begin
                    if (accept1_s) begin
                        data1_q <= in_data;
                        cnt1_q  <= cnt1_q + {{(cnt_w-1){1'b0}}, 1'b1};
                    end else if (out1_ready) begin
                        st1_q <= EMPTY;
                    end
                end
                default: st1_q <= EMPTY;
            endcase
        end
    end

    // Port 2 FSM: same behaviour as port 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st2_q   <= EMPTY;
            data2_q <= {width{1'b0}};
            cnt2_q  <= {cnt_w{1'b0}};
        end else begin
            case (st2_q)
                EMPTY: begin
                    if (accept2_s) begin
                        st2_q   <= FULL;
                        data2_q <= in_data;
                        cnt2_q  <= cnt2_q + {{(cnt_w-1){1'b0}}, 1'b1};
                    end
                end
                FULL: begin
                    if (accept2_s) begin
                        data2_q <= in_data;
                        cnt2_q  <= cnt2_q + {{(cnt_w-1){1'b0}}, 1'b1};
                    end else if (out2_ready) begin
                        st2_q <= EMPTY;
                    end
                end
                default: st2_q <= EMPTY;
            endcase
        end
    end

    assign out1_valid = (st1_q == FULL);
    assign out2_valid = (st2_q == FULL);
    assign out1_data  = data1_q;
    assign out2_data  = data2_q;
    assign cnt1       = cnt1_q;
    assign cnt2       = cnt2_q;

endmodule
